// File: rtl/dmem_arbiter.sv
// Data memory arbiter: nand_cpu load/store port vs. debug port on one D_MEM.
// CPU wins by default; a bounded wait counter forces the debug port through.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cpu_halt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {
        CPU_PRI,
        DBG_PRI
    } pri_e;

    pri_e             pri;
    logic             cpu_grant;
    logic             dbg_grant;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       rd_tag_q, rd_tag_d;

    always_comb begin
        pri       = (wait_cnt_q == CNT_MAX) ? DBG_PRI : CPU_PRI;
        dbg_grant = dbg_req & (~cpu_req | cpu_halt | (pri == DBG_PRI));
        cpu_grant = cpu_req & ~dbg_grant;
        cpu_stall = cpu_req & dbg_grant;
        dbg_ack   = dbg_grant;
    end

    always_comb begin
        mem_en    = cpu_grant | dbg_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_grant) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Counts consecutive denied debug cycles; any gap in dbg_req restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if (dbg_req & ~dbg_grant) begin
            if (wait_cnt_q == CNT_MAX) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_tag_d = {cpu_grant & ~cpu_we, dbg_grant & ~dbg_we};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt_q <= '0;
            rd_tag_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    always_comb begin
        cpu_rvalid = rd_tag_q[1];
        dbg_rvalid = rd_tag_q[0];
        cpu_rdata  = rd_tag_q[1] ? mem_rdata : '0;
        dbg_rdata  = rd_tag_q[0] ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: grant prediction per cycle, read
// returns checked by a separate monitor against a reference memory.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cpu_halt, cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [15:0] dbg_addr, dbg_wdata;
    logic        dbg_ack, dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    dmem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .cpu_halt(cpu_halt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory standing in for D_MEM
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        bit          port;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [0:255];
    int          streak = 0;

    // Monitor: read returns
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, e.port == 1'b0});
            chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, e.port == 1'b1});
            chk("cpu_rdata", {16'b0, cpu_rdata},
                {16'b0, (e.port == 1'b0) ? e.data : 16'h0});
            chk("dbg_rdata", {16'b0, dbg_rdata},
                {16'b0, (e.port == 1'b1) ? e.data : 16'h0});
        end else if (cpu_rvalid || dbg_rvalid ||
                     cpu_rdata != 16'h0 || dbg_rdata != 16'h0) begin
            chk("spurious_rd", {14'b0, cpu_rvalid, dbg_rvalid, cpu_rdata},
                32'h0);
        end
    end

    task automatic step(input logic h,
                        input logic cr, input logic cw,
                        input logic [15:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw,
                        input logic [15:0] da, input logic [15:0] dd,
                        output logic gc, output logic gd);
        logic        ew;
        logic [15:0] ea, ed;
        @(posedge clk);
        #1;
        cpu_halt = h;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        gd = dr && (!cr || h || streak == MAX_WAIT);
        gc = cr && !gd;
        ew = gd ? dw : (gc ? cw : 1'b0);
        ea = gd ? da : (gc ? ca : 16'h0);
        ed = gd ? dd : (gc ? cd : 16'h0);
        @(negedge clk);
        chk("dbg_ack", {31'b0, dbg_ack}, {31'b0, gd});
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cr && gd});
        chk("mem_en", {31'b0, mem_en}, {31'b0, gc || gd});
        chk("mem_we", {31'b0, mem_we}, {31'b0, ew});
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, ea});
        chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, ed});
        if (gc || gd) begin
            if (ew) ref_mem[ea[7:0]] = ed;
            else    q.push_back('{port: gd, data: ref_mem[ea[7:0]], due: cyc + 1});
        end
        if (dr && !gd) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
        else           streak = 0;
    endtask

    task automatic idle();
        logic a, b;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    initial begin
        logic gc, gd;
        logic cp_v, cp_we, dp_v, dp_we, h;
        logic [15:0] cp_a, cp_d, dp_a, dp_d;

        n_rst = 1'b0;
        cpu_halt = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        #12;
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_ack", {31'b0, dbg_ack}, 32'h0);
        chk("rst_mem", {mem_en, mem_we, mem_addr[7:0], mem_wdata}, 32'h0);
        chk("rst_rv", {cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata[13:0]}, 32'h0);
        chk("rst_wait", {29'b0, dut.wait_cnt_q}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        idle();

        for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 0, 1, 1, 16'(a), 16'h0, gc, gd);

        // CPU only: write then read back
        step(0, 1, 1, 16'd3, 16'h0003, 0, 0, 0, 0, gc, gd);
        step(0, 1, 0, 16'd3, 16'h0, 0, 0, 0, 0, gc, gd);
        idle();

        // Debug only
        step(0, 0, 0, 0, 0, 1, 1, 16'd0, 16'h0009, gc, gd);
        chk("dbg_wr_ack", {31'b0, dbg_ack}, 32'h1);
        step(0, 0, 0, 0, 0, 1, 0, 16'd0, 16'h0, gc, gd);
        idle();

        // Contention with cpu_req held
        step(0, 0, 0, 0, 0, 1, 1, 16'd5, 16'h1234, gc, gd);
        for (int i = 0; i <= MAX_WAIT; i++) begin
            step(0, 1, 1, 16'(8 + i), 16'(i), 1, 0, 16'd5, 16'h0, gc, gd);
            chk("cont_ack", {31'b0, dbg_ack}, {31'b0, i == MAX_WAIT});
            chk("cont_stall", {31'b0, cpu_stall}, {31'b0, i == MAX_WAIT});
        end
        step(0, 1, 1, 16'd12, 16'h55, 0, 0, 0, 0, gc, gd);
        chk("cont_rv", {15'b0, dbg_rvalid, dbg_rdata}, 32'h0001_1234);

        // Halted: debug always wins
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 16'd3, 16'h0, 1, 1, 16'(i), 16'(16'h40 + i), gc, gd);
            chk("halt_ack", {31'b0, dbg_ack}, 32'h1);
            chk("halt_stall", {31'b0, cpu_stall}, 32'h1);
        end
        idle();

        // Reset mid-read
        step(0, 1, 0, 16'd3, 16'h0, 1, 0, 16'd0, 16'h0, gc, gd);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        cpu_req = 0; dbg_req = 0; cpu_halt = 0;
        q.delete();
        streak = 0;
        @(negedge clk);
        chk("rstmid_rv", {31'b0, cpu_rvalid}, 32'h0);
        chk("rstmid_wait", {29'b0, dut.wait_cnt_q}, 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        chk("rstrel_rv", {31'b0, cpu_rvalid}, 32'h0);
        chk("rstrel_wait", {29'b0, dut.wait_cnt_q}, 32'h0);

        // Randomized traffic honoring hold-until-taken
        cp_v = 0; dp_v = 0;
        cp_we = 0; dp_we = 0; cp_a = 0; cp_d = 0; dp_a = 0; dp_d = 0;
        for (int i = 0; i < 400; i++) begin
            if (!cp_v && $urandom_range(0, 9) < 6) begin
                cp_v = 1;
                cp_we = 1'($urandom_range(0, 1));
                cp_a = 16'($urandom_range(0, 7));
                cp_d = 16'($urandom);
            end
            if (dp_v && $urandom_range(0, 19) == 0) begin
                dp_v = 0;
            end else if (!dp_v && $urandom_range(0, 9) < 4) begin
                dp_v = 1;
                dp_we = 1'($urandom_range(0, 1));
                dp_a = 16'($urandom_range(0, 7));
                dp_d = 16'($urandom);
            end
            h = ($urandom_range(0, 9) == 0);
            step(h, cp_v, cp_we, cp_a, cp_d, dp_v, dp_we, dp_a, dp_d, gc, gd);
            if (gc) cp_v = 0;
            if (gd) dp_v = 0;
        end
        idle();
        idle();
        chk("q_drained", q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data memory arbiter placed between the `nand_cpu` core's load/store path and `D_MEM`. It adds a second requester, the debug/test port, so benches and the future debug loader can write operands and read results through real memory cycles instead of poking `D_MEM.core` hierarchically. The CPU has default priority. A bounded starvation counter guarantees the debug port is eventually served. Once the CPU halts, the debug port owns memory outright.

## Interface

Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory data width.
- `MAX_WAIT`, default 4: consecutive denied debug cycles before the debug port is forced through; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `cpu_halt`  in  1  CPU halted (the core's `halt`).
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_stall`  out  1  CPU request not taken this cycle; hold request.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DATA_W  CPU read data.
- `dbg_req`  in  1  debug access request.
- `dbg_we`  in  1  debug write enable.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_ack`  out  1  debug request taken this cycle.
- `dbg_rvalid`  out  1  debug read data valid.
- `dbg_rdata`  out  DATA_W  debug read data.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after a read access (synchronous read).

## Operation

Requester rules:
- A requester holds `*_req`, `*_we`, `*_addr` and `*_wdata` stable until it is taken.
- CPU taken = `cpu_req & ~cpu_stall`.
- Debug taken = `dbg_ack`.

Grant rule, evaluated combinationally each cycle:
- `dbg_grant = dbg_req & (~cpu_req | cpu_halt | wait_cnt == MAX_WAIT)`
- `cpu_grant = cpu_req & ~dbg_grant`
- `cpu_stall = cpu_req & dbg_grant`
- `dbg_ack = dbg_grant`

Memory drive:
- `mem_en = cpu_grant | dbg_grant`.
- `mem_we`, `mem_addr` and `mem_wdata` come from the granted requester.
- When neither requester is granted, `mem_we`, `mem_addr` and `mem_wdata` are all 0.

Starvation counter `wait_cnt`:
- Width is `$clog2(MAX_WAIT+1)`.
- Increments each cycle `dbg_req & ~dbg_grant`, saturating at `MAX_WAIT`.
- Clears to 0 on `dbg_grant` or when `dbg_req` is low.

Priority states:
- CPU_PRI when `wait_cnt < MAX_WAIT`.
- DBG_PRI when `wait_cnt == MAX_WAIT`.
- DBG_PRI returns to CPU_PRI on the cycle after the debug grant.

Read return:
- A 2-bit register `rd_tag` records {cpu read granted, dbg read granted} at each edge.
- `cpu_rvalid = rd_tag[1]` and `dbg_rvalid = rd_tag[0]`; at most one is set.
- `*_rdata = mem_rdata` when the matching `*_rvalid` is high, else 0.
- Writes produce no `*_rvalid`.

## Timing

- Reset values:
  - `wait_cnt` = 0 and `rd_tag` = 0.
  - `cpu_rvalid`, `dbg_rvalid`, `cpu_rdata` and `dbg_rdata` are 0.
  - `cpu_stall`, `dbg_ack` and the `mem_*` outputs follow their inputs combinationally; with all `*_req` low they are 0.
- Grant and memory drive: 0-cycle (combinational) latency. Read data: 1 cycle after the grant.
- Throughput: one access per cycle; back-to-back accesses from the same requester are allowed.
- Contention with `cpu_req` held high: the debug port is denied for exactly `MAX_WAIT` cycles and granted on cycle `MAX_WAIT` (counting from 0).
  - The CPU stalls for exactly that one cycle.
  - The counter then restarts.
- `cpu_halt` high: the debug port wins every conflict. `wait_cnt` is irrelevant.
- Same-address requests from both ports in one cycle: only the grant winner accesses memory. The loser accesses on a later cycle, so it observes the winner's write.
- Reset asserted mid-operation: `rd_tag` clears asynchronously. A read granted before reset produces no `rvalid` after release, and `wait_cnt` restarts at 0.
- `dbg_req` dropped before it is taken: no access occurs and `wait_cnt` clears.

## Test plan

- Reset: `n_rst` = 0 with all requests low → every output 0; after release, idle → `mem_en` = 0.
- CPU only: write addr 3 = 0x0003 at cycle 0, read addr 3 at cycle 1 → `cpu_stall` stays 0; `cpu_rvalid` = 1 with `cpu_rdata` = 0x0003 at cycle 2.
- Debug only: write addr 0 = 0x0009 → `dbg_ack` = 1 in the same cycle. Read addr 0 on the next cycle → `dbg_rvalid` = 1 with `dbg_rdata` = 0x0009 one cycle later.
- Contention, `MAX_WAIT` = 4: `cpu_req` held continuously and `dbg_req` (read addr 5, preloaded 0x1234) from cycle 0 → `dbg_ack` is 0 on cycles 0–3 and 1 on cycle 4. `cpu_stall` = 1 on cycle 4 only. `dbg_rvalid` = 1 with 0x1234 on cycle 5.
- Halted: `cpu_halt` = 1 with both requesting → `dbg_ack` = 1 and `cpu_stall` = 1 immediately, every cycle.
- Reset mid-read: CPU read granted at cycle 0, `n_rst` pulsed low during cycle 1 → `cpu_rvalid` stays 0, and `wait_cnt` is 0 after release.
